imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_word_assembler.sv | 38 +++
 rtl/imem_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum,
    StWait,
    StDone,
    StError
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned LEN_W         = 16;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs consecutive bytes into little-endian 32-bit words; flags the 4th byte of each word.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_idx;
  logic [23:0] r_lo;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx <= '0;
      r_lo  <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_byte_valid) begin
      r_idx <= r_idx + 2'd1;
      case (r_idx)
        2'd0:    r_lo[7:0]   <= i_byte;
        2'd1:    r_lo[15:8]  <= i_byte;
        2'd2:    r_lo[23:16] <= i_byte;
        default: ;
      endcase
    end
  end

  // The top byte is taken straight from the input so the word is ready on its own cycle.
  assign o_word_valid = i_byte_valid && (r_idx == 2'd3);
  assign o_word       = {i_byte, r_lo};

endmodule

// File: rtl/imem_loader.sv
// Frame-driven instruction-memory loader; holds the core in reset until the image is written.
// Optional checksum byte after the data is enabled with IMEM_LOADER_CSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  input  logic              i_reload,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_rst,
  output logic              o_done,
  output logic              o_error
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic               r_cpu_rst;
  logic               r_done;
  logic               r_error;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]         r_csum;
`endif

  logic               w_acc;
  logic               w_word_valid;
  logic [31:0]        w_word;
  logic [LEN_W-1:0]   w_len_full;
  logic               w_last;

  assign o_in_ready = !i_rst && (r_state inside {StIdle, StLenLo, StLenHi, StData, StCsum});
  assign w_acc      = i_in_valid && o_in_ready;
  assign w_len_full = {i_in_data, r_len[7:0]};
  assign w_last     = (r_cnt == r_len - LEN_W'(1));

  imem_loader_word_assembler u_word_assembler (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (w_acc && (r_state == StLenHi)),
    .i_byte_valid (w_acc && (r_state == StData)),
    .i_byte       (i_in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_len     <= '0;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_we <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      if (w_acc && (r_state inside {StLenLo, StLenHi, StData})) r_csum <= r_csum ^ i_in_data;
`endif
      case (r_state)
        StIdle: begin
          if (w_acc && (i_in_data == SYNC_BYTE)) begin
            r_state <= StLenLo;
`ifdef IMEM_LOADER_CSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        StLenLo: begin
          if (w_acc) begin
            r_len[7:0] <= i_in_data;
            r_state    <= StLenHi;
          end
        end
        StLenHi: begin
          if (w_acc) begin
            r_len[15:8] <= i_in_data;
            r_cnt       <= '0;
            if (w_len_full == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
              r_state <= StCsum;
`else
              r_state <= StWait;
`endif
            end else if (32'(w_len_full) > DEPTH) begin
              r_state <= StError;
              r_error <= 1'b1;
            end else begin
              r_state <= StData;
            end
          end
        end
        StData: begin
          if (w_word_valid) begin
            r_we    <= 1'b1;
            r_addr  <= r_cnt[ADDR_W-1:0];
            r_wdata <= w_word;
            r_cnt   <= r_cnt + LEN_W'(1);
            if (w_last) begin
`ifdef IMEM_LOADER_CSUM_EN
              r_state <= StCsum;
`else
              r_state <= StWait;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        StCsum: begin
          if (w_acc) begin
            if (i_in_data == r_csum) begin
              r_state <= StWait;
            end else begin
              r_state <= StError;
              r_error <= 1'b1;
            end
          end
        end
`endif
        // One spare cycle lets the final write land before the core leaves reset.
        StWait: begin
          r_state   <= StDone;
          r_cpu_rst <= 1'b0;
          r_done    <= 1'b1;
        end
        StDone, StError: begin
          if (i_reload) begin
            r_state   <= StIdle;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_cpu_rst    = r_cpu_rst;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; frames gain a checksum byte when IMEM_LOADER_CSUM_EN is set.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 6;
`ifdef IMEM_LOADER_CSUM_EN
  localparam int DoneLat = 2;
`else
  localparam int DoneLat = 1;
`endif

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_in_valid = 1'b0;
  logic [7:0]        i_in_data = 8'h00;
  logic              i_reload = 1'b0;
  logic              o_in_ready;
  logic              o_imem_we;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [31:0]       o_imem_wdata;
  logic              o_cpu_rst;
  logic              o_done;
  logic              o_error;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_we_cyc = 0;
  int          done_cyc = 0;
  logic        prev_done = 1'b0;
  bit          stall = 1'b0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] words[$];

  imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_in_valid   (i_in_valid),
    .i_in_data    (i_in_data),
    .o_in_ready   (o_in_ready),
    .i_reload     (i_reload),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_cpu_rst    (o_cpu_rst),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_imem_we) begin
      wa.push_back(32'(o_imem_addr));
      wd.push_back(o_imem_wdata);
      last_we_cyc = cyc;
    end
    if (o_done && !prev_done) done_cyc = cyc;
    prev_done = o_done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the byte's accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (stall) begin
      i_in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    i_in_valid = 1'b1;
    i_in_data  = b;
    while (!o_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
  endtask

  task automatic send_frame();
    int         n = words.size();
    logic [7:0] x;
    logic [7:0] b;
    x = n[7:0] ^ n[15:8];
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = words[i][8*k +: 8];
        x = x ^ b;
        send_byte(b);
      end
    end
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(o_done || o_error) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk1("end_reached", o_done || o_error, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reload();
    i_reload = 1'b1;
    @(posedge clk);
    #1;
    i_reload = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready", o_in_ready, 1'b0);
    chk1("rst_we", o_imem_we, 1'b0);
    chk32("rst_addr", 32'(o_imem_addr), 32'd0);
    chk32("rst_wdata", o_imem_wdata, 32'd0);
    chk1("rst_cpu_rst", o_cpu_rst, 1'b1);
    chk1("rst_done", o_done, 1'b0);
    chk1("rst_error", o_error, 1'b0);
    i_rst = 1'b0;
    #1;
    chk1("idle_in_ready", o_in_ready, 1'b1);

    // Two-word image.
    clear_log();
    words = '{32'h00100513, 32'h00200593};
    send_frame();
    wait_end();
    chk32("t1_nwr", wa.size(), 32'd2);
    chk32("t1_a0", wa[0], 32'd0);
    chk32("t1_d0", wd[0], 32'h00100513);
    chk32("t1_a1", wa[1], 32'd1);
    chk32("t1_d1", wd[1], 32'h00200593);
    chk32("t1_done_lat", done_cyc - last_we_cyc, DoneLat);
    chk1("t1_done", o_done, 1'b1);
    chk1("t1_cpu_rst", o_cpu_rst, 1'b0);
    chk1("t1_in_ready", o_in_ready, 1'b0);

    // Reload from DONE, then leading junk before the frame.
    pulse_reload();
    chk1("rl_done", o_done, 1'b0);
    chk1("rl_cpu_rst", o_cpu_rst, 1'b1);
    clear_log();
    send_byte(8'h00);
    send_byte(8'hFF);
    words = '{32'hDEADBEEF};
    send_frame();
    wait_end();
    chk32("t2_nwr", wa.size(), 32'd1);
    chk32("t2_a0", wa[0], 32'd0);
    chk32("t2_d0", wd[0], 32'hDEADBEEF);

    // Oversize length is rejected without any write.
    pulse_reload();
    clear_log();
    send_byte(8'hA5);
    send_byte(8'h41);
    send_byte(8'h00);
    chk1("t3_error", o_error, 1'b1);
    chk1("t3_cpu_rst", o_cpu_rst, 1'b1);
    chk1("t3_done", o_done, 1'b0);
    chk1("t3_in_ready", o_in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk32("t3_nwr", wa.size(), 32'd0);
    pulse_reload();
    chk1("t3_rl_error", o_error, 1'b0);
    chk1("t3_rl_ready", o_in_ready, 1'b1);
    words = '{32'h12345678};
    send_frame();
    wait_end();
    chk1("t3_reload_done", o_done, 1'b1);
    chk32("t3_d0", wd[0], 32'h12345678);

    // Full-capacity image: LEN == DEPTH.
    pulse_reload();
    clear_log();
    words.delete();
    for (int i = 0; i < 64; i++) words.push_back({4{8'(i)}});
    send_frame();
    wait_end();
    chk1("t4_done", o_done, 1'b1);
    chk1("t4_error", o_error, 1'b0);
    chk32("t4_nwr", wa.size(), 32'd64);
    chk32("t4_a63", wa[63], 32'd63);
    chk32("t4_d63", wd[63], 32'h3F3F3F3F);
    chk32("t4_d1", wd[1], 32'h01010101);

    // Empty image.
    pulse_reload();
    clear_log();
    words.delete();
    send_frame();
`ifndef IMEM_LOADER_CSUM_EN
    chk1("t5_done_early", o_done, 1'b0);
    @(posedge clk);
    #1;
    chk1("t5_done_lat", o_done, 1'b1);
`endif
    wait_end();
    chk1("t5_done", o_done, 1'b1);
    chk32("t5_nwr", wa.size(), 32'd0);

    // Three words with random input stalls.
    pulse_reload();
    clear_log();
    words = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    stall = 1'b1;
    send_frame();
    stall = 1'b0;
    wait_end();
    chk32("t6_nwr", wa.size(), 32'd3);
    chk32("t6_d0", wd[0], 32'h04030201);
    chk32("t6_d1", wd[1], 32'h08070605);
    chk32("t6_a2", wa[2], 32'd2);
    chk32("t6_d2", wd[2], 32'h0C0B0A09);

    // Reload during DATA is ignored.
    pulse_reload();
    clear_log();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    pulse_reload();
    chk1("t7_ready", o_in_ready, 1'b1);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h01 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
`endif
    wait_end();
    chk1("t7_done", o_done, 1'b1);
    chk32("t7_d0", wd[0], 32'hDDCCBBAA);

    // Reset mid-DATA aborts, then a fresh frame loads from address 0.
    pulse_reload();
    clear_log();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    chk32("t8_pre_d0", wd[0], 32'h44332211);
    i_rst = 1'b1;
    #1;
    chk1("t8_rst_ready", o_in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk1("t8_we", o_imem_we, 1'b0);
    chk32("t8_addr", 32'(o_imem_addr), 32'd0);
    chk32("t8_wdata", o_imem_wdata, 32'd0);
    chk1("t8_cpu_rst", o_cpu_rst, 1'b1);
    chk1("t8_done", o_done, 1'b0);
    i_rst = 1'b0;
    clear_log();
    words = '{32'h0A0B0C0D};
    send_frame();
    wait_end();
    chk1("t8_reload_done", o_done, 1'b1);
    chk32("t8_a0", wa[0], 32'd0);
    chk32("t8_d0", wd[0], 32'h0A0B0C0D);

`ifdef IMEM_LOADER_CSUM_EN
    // Checksum accept and reject.
    pulse_reload();
    clear_log();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h45);
    wait_end();
    chk1("cs_ok_done", o_done, 1'b1);
    chk1("cs_ok_error", o_error, 1'b0);
    chk32("cs_ok_d0", wd[0], 32'h44332211);
    pulse_reload();
    clear_log();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h46);
    wait_end();
    chk1("cs_bad_error", o_error, 1'b1);
    chk1("cs_bad_done", o_done, 1'b0);
    chk1("cs_bad_cpu_rst", o_cpu_rst, 1'b1);
    chk32("cs_bad_nwr", wa.size(), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
